out_port: RTL and testbench
===========================

// Module: out_port
// PURPOSE
//  Downstream output stage for the stack CPU's OUT instruction. Each word the CPU pops for output is
//  accepted into a small FIFO and mirrored on the LED byte. Each word is then serialised on a UART
//  TX line as two 8N1 frames, high byte first. The full flag gives the core back-pressure; the
//  overflow flag records writes dropped while the FIFO was full.
// PARAMETERS
//  CLKS_PER_BIT  16  clock cycles per UART bit (>=2); 868 for 115200 baud @100 MHz
//  DEPTH          4  FIFO entries, power of two, >=2; pointers are log2(DEPTH) bits and wrap naturally
// PORTS
//  clk       in   1   system clock, all state on posedge
//  rst_n     in   1   reset, asynchronous, active-low
//  wr_en     in   1   CPU presents an OUT word this cycle
//  wr_data   in  16   word to output
//  full      out  1   FIFO holds DEPTH words (combinational from count register)
//  empty     out  1   FIFO holds 0 words
//  overflow  out  1   sticky: a write arrived while full
//  busy      out  1   TX FSM not in IDLE
//  tx        out  1   UART serial line, idle high, registered
//  leds      out  8   low byte of last accepted word, registered
// BEHAVIOUR
//  Reset (async assert, sync deassert by design)
//   - tx=1, leds=0, overflow=0, busy=0, empty=1, full=0; FIFO pointers/count=0; FSM=IDLE.
//   - Assertion mid-frame aborts the frame at once: tx goes high, with no partial stop bit.
//  Write side
//   - Accept when wr_en && !full, using the count *before* this edge's pop.
//   - On accept: store at wr_ptr, wr_ptr+1, leds<=wr_data[7:0].
//   - wr_en while full: word dropped, leds unchanged, overflow<=1 (cleared only by reset).
//   - Accept and pop on the same edge: count unchanged.
//  TX FSM states: IDLE, START, DATA, STOP
//   - IDLE: if !empty, pop head into shreg[15:0], byte_sel<=0 (high), goto START; else tx=1.
//   - START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//   - DATA: tx=cur_byte[bit_idx], LSB first; CLKS_PER_BIT cycles per bit; after bit 7 -> STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles.
//     - If byte_sel==0: byte_sel<=1 (low byte), goto START with no idle gap.
//     - Else goto IDLE; a waiting word is popped on the next cycle (1 idle-high cycle between words).
//   - cur_byte = byte_sel ? shreg[7:0] : shreg[15:8].
//  Baud counter
//   - Counts 0..CLKS_PER_BIT-1, reloads on every bit boundary, held at 0 in IDLE.
//  Timing
//   - Write accepted at edge N: empty=0 after N; pop at edge N+1; tx falls after N+1.
//   - One word = 20*CLKS_PER_BIT cycles on the line, plus 1 IDLE cycle before the next pop.
//  FIFO storage is a plain register array; the head word is held in shreg, so a full FIFO plus an
//  in-flight word totals DEPTH+1 words in the block.
// TESTING (CLKS_PER_BIT=4, DEPTH=4)
//  1 Reset, then wr 0x1234 one cycle
//    -> leds=0x34; tx low 2 cycles after the wr cycle; decoded frames 0x12 then 0x34; busy 80 cycles.
//  2 Write 5 words back-to-back at cycle 0..4
//    -> all 5 accepted (first popped before 5th write); full asserts; 6th write sets overflow, leds
//       keep word 5.
//  3 Write 10 words, each only when !full -> pointers wrap; 20 frames decoded in write order.
//  4 Reset asserted mid-DATA of first frame -> tx=1 same cycle; FIFO empty; no further frames after
//    release.
//  5 wr_en when count==DEPTH on the edge the FSM pops -> word dropped, overflow=1, count stays DEPTH-1.
//  6 Idle 100 cycles with no writes -> tx stays 1, busy 0, empty 1.

Source files
------------

// File: rtl/out_port_if.sv
// out_port bus: CPU OUT write port plus status, LED and UART TX lines.
// master = CPU/bench side, slave = out_port.
interface out_port_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        busy;
  logic        tx;
  logic [7:0]  leds;

  modport master (
    output wr_en, wr_data,
    input  full, empty, overflow,
    input  busy, tx, leds
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, overflow,
    output busy, tx, leds
  );
endinterface

// File: rtl/out_port.sv
// OUT stage: words enter a FIFO, low byte mirrors on leds, each word
// goes out on tx as two 8N1 frames (high byte first). Ports: clk, rst_n, bus.
module out_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input logic      clk,
  input logic      rst_n,
  out_port_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            sel_q, sel_d;
  logic [15:0]     shreg_q, shreg_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     mem_d [DEPTH];
  logic            ovf_q, ovf_d;
  logic            tx_q, tx_d;
  logic [7:0]      leds_q, leds_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            baud_end;
  logic [7:0]      cur_byte_d;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.wr_en && !full;
  assign pop      = (state_q == IDLE) && !empty;
  assign baud_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.tx       = tx_q;
  assign bus.leds     = leds_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    leds_d   = leds_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      leds_d          = bus.wr_data[7:0];
    end
    if (bus.wr_en && full) begin
      ovf_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sel_d   = sel_q;
    shreg_d = shreg_q;
    cnt_d   = baud_end ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pop) begin
          shreg_d = mem_q[rd_ptr_q];
          sel_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (!sel_q) begin
            sel_d   = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered, so it is derived from the next-state values.
  always_comb begin
    cur_byte_d = sel_d ? shreg_d[7:0] : shreg_d[15:8];
    tx_d       = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sel_q    <= 1'b0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
      leds_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sel_q    <= sel_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
      leds_q   <= leds_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_out_port.sv
// Bench for out_port: cycle-level reference model of FIFO, flags,
// LEDs and the expected UART line, with directed and random stimulus.
module tb_out_port;

  localparam int C = 4;
  localparam int D = 4;
  localparam int WORD_CYC = 20 * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  out_port_if bus ();

  out_port #(
    .CLKS_PER_BIT(C),
    .DEPTH       (D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] q[$];
  logic [15:0] cur;
  int          rem;
  logic        ovf_m;
  logic [7:0]  leds_m;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int k, f, b;
    logic [7:0] by;
    if (rem == 0) return 1'b1;
    k  = WORD_CYC - rem;
    f  = k / (10 * C);
    b  = (k % (10 * C)) / C;
    by = (f != 0) ? cur[7:0] : cur[15:8];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  task automatic model_reset();
    q.delete();
    rem    = 0;
    cur    = '0;
    ovf_m  = 1'b0;
    leds_m = '0;
  endtask

  task automatic check_all(string tag);
    chk({tag, "_full"},  32'(bus.full),     32'(q.size() == D));
    chk({tag, "_empty"}, 32'(bus.empty),    32'(q.size() == 0));
    chk({tag, "_ovf"},   32'(bus.overflow), 32'(ovf_m));
    chk({tag, "_busy"},  32'(bus.busy),     32'(rem > 0));
    chk({tag, "_leds"},  32'(bus.leds),     32'(leds_m));
    chk({tag, "_tx"},    32'(bus.tx),       32'(exp_tx()));
  endtask

  task automatic step(string tag);
    bit was_full;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      was_full = (q.size() == D);
      if (rem > 0) begin
        rem--;
      end else if (q.size() > 0) begin
        cur = q.pop_front();
        rem = WORD_CYC;
      end
      if (bus.wr_en) begin
        if (!was_full) begin
          q.push_back(bus.wr_data);
          leds_m = bus.wr_data[7:0];
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(string tag, int n);
    bus.wr_en = 1'b0;
    repeat (n) step(tag);
  endtask

  task automatic drain(string tag);
    int n = 0;
    bus.wr_en = 1'b0;
    while ((rem > 0 || q.size() > 0) && n < 2000) begin
      step(tag);
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(n >= 2000), 32'd0);
    step(tag);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_tx",    32'(bus.tx),       32'd1);
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_empty", 32'(bus.empty),    32'd1);
    chk("rst_full",  32'(bus.full),     32'd0);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    chk("rst_leds",  32'(bus.leds),     32'd0);
    bus.wr_en = 1'b0;
    step("rst");
    step("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    int sent;
    int n;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    model_reset();
    step("init");
    do_reset();

    // 1: single word
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h1234;
    step("s1");
    bus.wr_en = 1'b0;
    chk("s1_leds34", 32'(bus.leds), 32'h34);
    step("s1");
    chk("s1_tx_low", 32'(bus.tx), 32'd0);
    drain("s1");

    // 2: five words back to back, then a sixth overflows
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'($urandom);
      step("s2");
    end
    chk("s2_ovf", 32'(bus.overflow), 32'd1);
    drain("s2");

    // 3: ten words, written only while not full
    do_reset();
    sent = 0;
    n    = 0;
    while (sent < 10 && n < 3000) begin
      bus.wr_en   = (q.size() < D);
      bus.wr_data = 16'($urandom);
      if (bus.wr_en) sent++;
      step("s3");
      n++;
    end
    chk("s3_sent", 32'(sent), 32'd10);
    drain("s3");
    chk("s3_no_ovf", 32'(bus.overflow), 32'd0);

    // 4: reset in the middle of the first data byte
    do_reset();
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'hA5C3;
    step("s4");
    idle("s4", 8);
    do_reset();
    idle("s4_after", 100);

    // 5: write while full on the pop edge
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'($urandom);
      step("s5_fill");
    end
    bus.wr_en = 1'b0;
    n = 0;
    while (!(rem == 0 && q.size() == D) && n < 500) begin
      step("s5_wait");
      n++;
    end
    chk("s5_wait_timeout", 32'(n >= 500), 32'd0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'hBEEF;
    step("s5");
    bus.wr_en = 1'b0;
    chk("s5_overflow", 32'(bus.overflow), 32'd1);
    chk("s5_not_full", 32'(bus.full),     32'd0);
    drain("s5");

    // 6: long idle
    do_reset();
    idle("s6", 100);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_data = 16'($urandom);
      step("rnd");
    end
    drain("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
